fft_in_framer: RTL and testbench

- Upstream neighbour of the FFT core: accepts a sporadic sample stream under valid/ready and emits contiguous frames of exactly FFT_SIZE samples.
- The FFT core's input counter restarts whenever din_valid drops, so every frame must arrive as an unbroken burst, followed by an idle gap.
- Samples are buffered in a two-bank ping-pong memory, so one frame fills while the previous one drains.

---
 rtl/fft_pkg.sv | 18 +
 rtl/framer_bank_ram.sv | 33 +++
 rtl/fft_in_framer.sv | 158 +++++++++++++++
 tb/tb_fft_in_framer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT front end: complex sample storage and the
// input framer's read-side state encoding.
package fft_pkg;

    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } framer_state_t;

endpackage

// File: rtl/framer_bank_ram.sv
// Simple dual-port RAM backing both ping-pong banks; address is {bank, ptr}.
// One write port, one read port with a registered output cleared by rst.
module framer_bank_ram #(
    parameter int DEPTH = 32,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read data holds its last value between bursts.
    always_ff @(posedge clk) begin
        if (rst)       rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_in_framer.sv
// Collects a sporadic sample stream into ping-pong banks and replays each
// full bank as an unbroken FFT_SIZE-beat burst followed by GAP_CYCLES idle.
// Optional stall counter: define FFT_IN_FRAMER_OVF_CNT_EN.
module fft_in_framer
    import fft_pkg::*;
#(
    parameter int FFT_SIZE   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] din_re,
    input  logic [SAMPLE_W-1:0] din_im,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [SAMPLE_W-1:0] dout_re,
    output logic [SAMPLE_W-1:0] dout_im,
    output logic                dout_valid,
    output logic                dout_last
`ifdef FFT_IN_FRAMER_OVF_CNT_EN
    ,
    output logic [31:0]         ovf_count
`endif
);

    localparam int PW = $clog2(FFT_SIZE);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(FFT_SIZE - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    framer_state_t state_q, state_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    full_q, full_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          vld_q, last_q;

    logic     wr_fire, wr_done, rd_en, rd_done;
    complex_t wr_sample, rd_sample;

    assign din_ready = ~rst & ~full_q[wr_bank_q];
    assign wr_fire   = din_valid & din_ready;
    assign wr_done   = wr_fire & (wr_ptr_q == PTR_LAST);
    assign rd_en     = (state_q == BURST);
    assign rd_done   = rd_en & (rd_ptr_q == PTR_LAST);
    assign wr_sample = '{re: din_re, im: din_im};

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        full_d    = full_q;
        gap_cnt_d = gap_cnt_q;

        // Write and read always sit on different banks, so both flag
        // updates can land on the same edge.
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (wr_done) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_done) full_d[rd_bank_q] = 1'b0;

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = BURST;
                    rd_ptr_d = '0;
                end
            end
            BURST: begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (rd_done) begin
                    rd_bank_d = ~rd_bank_q;
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                // Jump straight to BURST when the next bank is ready so the
                // gap between back-to-back frames is exactly GAP_CYCLES.
                if (gap_cnt_q == GAP_LAST) begin
                    if (full_q[rd_bank_q]) begin
                        state_d  = BURST;
                        rd_ptr_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            full_q    <= '0;
            gap_cnt_q <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            full_q    <= full_d;
            gap_cnt_q <= gap_cnt_d;
            vld_q     <= rd_en;
            last_q    <= rd_done;
        end
    end

    framer_bank_ram #(
        .DEPTH (2 * FFT_SIZE),
        .W     ($bits(complex_t)),
        .AW    (PW + 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_fire),
        .waddr_i ({wr_bank_q, wr_ptr_q}),
        .wdata_i (wr_sample),
        .re_i    (rd_en),
        .raddr_i ({rd_bank_q, rd_ptr_q}),
        .rdata_o (rd_sample)
    );

    assign dout_re    = rd_sample.re;
    assign dout_im    = rd_sample.im;
    assign dout_valid = vld_q;
    assign dout_last  = last_q;

`ifdef FFT_IN_FRAMER_OVF_CNT_EN
    logic [31:0] ovf_q;

    always_ff @(posedge clk) begin
        if (rst)                                     ovf_q <= '0;
        else if (din_valid & ~din_ready & ~&ovf_q)   ovf_q <= ovf_q + 32'd1;
    end

    assign ovf_count = ovf_q;
`endif

endmodule

// File: tb/tb_fft_in_framer.sv
// Scoreboard bench for fft_in_framer: accepted samples are queued in order and
// a negedge monitor checks every burst beat, burst framing and gap length.
module tb_fft_in_framer;

    localparam int N   = 16;
    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din_re, din_im;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] dout_re, dout_im;
    logic        dout_valid, dout_last;
`ifdef FFT_IN_FRAMER_OVF_CNT_EN
    logic [31:0] ovf_count;
`endif

    fft_in_framer #(.FFT_SIZE(N), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_re     (din_re),
        .din_im     (din_im),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
`ifdef FFT_IN_FRAMER_OVF_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted sample must reappear once, in order.
    logic [31:0] exp_q[$];
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc_cyc = 0;
    int first_stall = -1;
    int stall_base = 0;
    int stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            stall_cnt = 0;
        end else if (din_valid && din_ready) begin
            exp_q.push_back({din_re, din_im});
            acc_cnt++;
            last_acc_cyc = cyc + 1;
        end else if (din_valid && !din_ready) begin
            stall_cnt++;
            if (first_stall < 0) first_stall = acc_cnt - stall_base;
        end
    end

    // Monitor: data, dout_last placement, burst length and gap length.
    int beat = 0;
    int idle_run = 1000;
    int nbursts = 0;
    int burst_start_cyc = 0;
    int gap_q[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            beat = 0;
            idle_run = 1000;
        end else if (dout_valid) begin
            if (beat == 0) begin
                nbursts++;
                burst_start_cyc = cyc;
                gap_q.push_back(idle_run);
                chk("gap_min", 32'(idle_run >= GAP), 32'd1);
            end
            idle_run = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {dout_re, dout_im}, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("dout_data", {dout_re, dout_im}, e);
            end
            chk("dout_last", 32'(dout_last), 32'(beat == N - 1));
            beat = (beat == N - 1) ? 0 : beat + 1;
        end else begin
            if (beat != 0) begin
                chk("burst_len", 32'(beat), 32'(N));
                beat = 0;
            end
            if (dout_last) chk("last_without_valid", 32'(dout_last), 32'd0);
            idle_run++;
        end
    end

    // Present samples until n more have been accepted. pat 0: re=k, im=-k.
    task automatic send(input int n, input int pct, input int pat);
        int target, k, seq, guard;
        target = acc_cnt + n;
        k = 0;
        seq = -1;
        guard = 0;
        while (acc_cnt < target && !rst) begin
            if (acc_cnt != seq) begin
                seq = acc_cnt;
                if (pat == 0) begin
                    din_re = 16'(k);
                    din_im = 16'(-k);
                end else begin
                    {din_re, din_im} = $urandom;
                end
                k++;
            end
            din_valid = ($urandom_range(99) < pct);
            @(posedge clk);
            #1;
            guard++;
            if (guard > 4000) begin
                chk("send_timeout", 32'(acc_cnt), 32'(target));
                break;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (GAP + 4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb0, nb;
        rst = 1'b1;
        din_valid = 1'b0;
        din_re = '0;
        din_im = '0;

        // Reset state and idle behaviour.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        do_reset();
        @(negedge clk);
        chk("idle_din_ready", 32'(din_ready), 32'd1);
        chk("idle_dout_valid", 32'(dout_valid), 32'd0);
        chk("idle_dout", {dout_re, dout_im}, 32'd0);
        chk("idle_dout_last", 32'(dout_last), 32'd0);

        // One ramp frame: latency and ordering.
        nb0 = nbursts;
        send(N, 100, 0);
        drain();
        chk("ramp_bursts", 32'(nbursts - nb0), 32'd1);
        chk("ramp_latency", 32'(burst_start_cyc - last_acc_cyc), 32'd2);

        // Three frames with valid held high: backpressure and exact gaps.
        nb0 = nbursts;
        gap_q.delete();
        stall_base = acc_cnt;
        first_stall = -1;
        send(3 * N, 100, 1);
        drain();
        chk("stall_after", 32'(first_stall), 32'(2 * N));
        chk("hold_bursts", 32'(nbursts - nb0), 32'd3);
        chk("hold_gap_count", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            chk("hold_gap1", 32'(gap_q[1]), 32'(GAP));
            chk("hold_gap2", 32'(gap_q[2]), 32'(GAP));
        end

        // Ten frames with 50% random valid.
        nb0 = nbursts;
        send(10 * N, 50, 1);
        drain();
        chk("rand_bursts", 32'(nbursts - nb0), 32'd10);

        // Reset mid-burst with a second frame partially written.
        send(N, 100, 1);
        fork
            send(N / 2, 100, 1);
            begin
                int seen, guard;
                seen = 0;
                guard = 0;
                while (seen < 6 && guard < 200) begin
                    @(negedge clk);
                    if (dout_valid) seen++;
                    guard++;
                end
                chk("rst_beat_reached", 32'(seen), 32'd6);
                #1 rst = 1'b1;
            end
        join
        @(negedge clk);
        chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
        chk("midrst_din_ready", 32'(din_ready), 32'd0);
        chk("midrst_dout_last", 32'(dout_last), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_din_ready", 32'(din_ready), 32'd1);
        nb0 = nbursts;
        send(N, 100, 1);
        drain();
        chk("postrst_bursts", 32'(nbursts - nb0), 32'd1);

`ifdef FFT_IN_FRAMER_OVF_CNT_EN
        do_reset();
        @(negedge clk);
        chk("ovf_after_rst", ovf_count, 32'd0);
        send(6 * N, 100, 1);
        drain();
        nb = stall_cnt;
        chk("ovf_stalls_seen", 32'(nb != 0), 32'd1);
        chk("ovf_count", ovf_count, 32'(nb));
        do_reset();
        @(negedge clk);
        chk("ovf_cleared", ovf_count, 32'd0);
`else
        nb = 0;
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
